// File: rtl/bist_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : bist_checker_if
//  Purpose  : Read-response bundle between the memory BIST path (address /
//             pattern generator plus memory under test) and the checker.
//  Signals  : RD_VALID  - read strobe from the generator (CTRL_RINC)
//             RD_ADDR   - address of that read (READ_ADDR)
//             RD_DATA   - memory read data, already memory-latency aligned
//             EXPECTED  - expected data, aligned with RD_DATA
//  Modports : master (generator/memory side), slave (checker side)
//  Revision : 1.0 - initial release
// ============================================================================
interface bist_checker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  RD_VALID;
    logic [ADDR_WIDTH-1:0] RD_ADDR;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic [DATA_WIDTH-1:0] EXPECTED;

    modport master (
        output RD_VALID,
        output RD_ADDR,
        output RD_DATA,
        output EXPECTED
    );

    modport slave (
        input RD_VALID,
        input RD_ADDR,
        input RD_DATA,
        input EXPECTED
    );
endinterface
`default_nettype wire

// File: rtl/bist_checker.sv
`default_nettype none
// ============================================================================
//  Module   : bist_checker
//  Purpose  : Memory BIST response checker. Delays the read strobe/address
//             so they line up with read data, compares against expected
//             data and accumulates the verdict of one full pass.
//  Ports    : CLK, RST (sync, active-low), BIST_EN (start / abort)
//             rd              - read-response bundle (slave modport)
//             BUSY            - pass in progress
//             DONE / PASS     - pass complete / complete with zero errors
//             FAIL            - sticky mismatch flag
//             ERR_CNT         - saturating mismatch count
//             FIRST_FAIL_ADDR - aligned address of first mismatch
//             FIRST_FAIL_SYN  - syndrome of first mismatch
//             FAIL_BITS       - OR of all syndromes of the pass
//  Revision : 1.0 - initial release
// ============================================================================
module bist_checker #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALIGN_DLY     = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     BIST_EN,
    bist_checker_if.slave            rd,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     PASS,
    output logic                     FAIL,
    output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
    output logic [ADDR_WIDTH-1:0]    FIRST_FAIL_ADDR,
    output logic [DATA_WIDTH-1:0]    FIRST_FAIL_SYN,
    output logic [DATA_WIDTH-1:0]    FAIL_BITS
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter value just before the final compare of a pass (2^ADDR_WIDTH - 1)
    localparam logic [ADDR_WIDTH:0] LAST_CMP = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t                  state;
    state_t                  state_nxt;
    logic                    v_a;
    logic [ADDR_WIDTH-1:0]   a_a;
    logic [ADDR_WIDTH:0]     cmp_cnt;
    logic                    start;
    logic                    do_cmp;
    logic                    last_cmp;
    logic                    mismatch;
    logic [DATA_WIDTH-1:0]   syn;

    // ------------------------------------------------------------------
    // Strobe/address alignment. Cleared on reset and on pass start so a
    // read sampled before the pass (or before a reset) is never compared.
    // ------------------------------------------------------------------
    generate
        if (ALIGN_DLY == 0) begin : g_no_align
            assign v_a = rd.RD_VALID;
            assign a_a = rd.RD_ADDR;
        end else begin : g_align
            logic [ALIGN_DLY-1:0]                 v_pipe;
            logic [ALIGN_DLY-1:0][ADDR_WIDTH-1:0] a_pipe;

            always_ff @(posedge CLK) begin
                if (!RST || start) begin
                    v_pipe <= '0;
                    a_pipe <= '0;
                end else begin
                    v_pipe[0] <= rd.RD_VALID;
                    a_pipe[0] <= rd.RD_ADDR;
                    for (int i = 1; i < ALIGN_DLY; i++) begin
                        v_pipe[i] <= v_pipe[i-1];
                        a_pipe[i] <= a_pipe[i-1];
                    end
                end
            end

            assign v_a = v_pipe[ALIGN_DLY-1];
            assign a_a = a_pipe[ALIGN_DLY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        do_cmp    = 1'b0;
        last_cmp  = 1'b0;
        syn       = rd.RD_DATA ^ rd.EXPECTED;
        mismatch  = |syn;
        case (state)
            S_IDLE: begin
                if (BIST_EN) begin
                    start     = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Abort wins over a compare landing in the same cycle.
                if (!BIST_EN) begin
                    state_nxt = S_IDLE;
                end else if (v_a) begin
                    do_cmp = 1'b1;
                    if (cmp_cnt == LAST_CMP) begin
                        last_cmp  = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!BIST_EN) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result accumulation. Results hold across abort and DONE->IDLE and
    // are only cleared when the next pass starts (or by reset).
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            PASS            <= 1'b0;
            FAIL            <= 1'b0;
            ERR_CNT         <= '0;
            FIRST_FAIL_ADDR <= '0;
            FIRST_FAIL_SYN  <= '0;
            FAIL_BITS       <= '0;
            cmp_cnt         <= '0;
        end else begin
            BUSY <= (state_nxt == S_RUN);
            if (start) begin
                DONE            <= 1'b0;
                PASS            <= 1'b0;
                FAIL            <= 1'b0;
                ERR_CNT         <= '0;
                FIRST_FAIL_ADDR <= '0;
                FIRST_FAIL_SYN  <= '0;
                FAIL_BITS       <= '0;
                cmp_cnt         <= '0;
            end else if (do_cmp) begin
                cmp_cnt <= cmp_cnt + (ADDR_WIDTH+1)'(1);
                if (mismatch) begin
                    if (ERR_CNT != {ERR_CNT_WIDTH{1'b1}}) begin
                        ERR_CNT <= ERR_CNT + ERR_CNT_WIDTH'(1);
                    end
                    FAIL_BITS <= FAIL_BITS | syn;
                    FAIL      <= 1'b1;
                    // FAIL still low means this is the first mismatch.
                    if (!FAIL) begin
                        FIRST_FAIL_ADDR <= a_a;
                        FIRST_FAIL_SYN  <= syn;
                    end
                end
                if (last_cmp) begin
                    DONE <= 1'b1;
                    // Include a mismatch on the final compare itself.
                    PASS <= (ERR_CNT == '0) && !mismatch;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bist_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bist_checker
//  Purpose  : Directed self-checking bench for bist_checker. Four checkers
//             (ALIGN_DLY 0/2/4, and a 2-bit error counter variant) share one
//             generator stream; a small memory model delays data/expected
//             by each checker's alignment depth.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bist_checker;

    logic       CLK;
    logic       RST;
    logic       BIST_EN;

    // Generator / memory model
    logic       gen_valid;
    logic [3:0] gen_addr;
    logic [7:0] gen_err;
    logic       stuck7;
    logic [7:0] gen_exp;
    logic [7:0] gen_data;
    logic [7:0] exp_h [1:4];
    logic [7:0] dat_h [1:4];

    // Checker outputs: index 0 = dly0, 1 = dly2, 2 = dly4, 3 = 2-bit counter
    logic       busy  [4];
    logic       done  [4];
    logic       pass  [4];
    logic       fail  [4];
    logic [7:0] err_cnt [3];
    logic [1:0] err_sat;
    logic [3:0] ffa   [4];
    logic [7:0] ffs   [4];
    logic [7:0] fbits [4];

    int n_checks = 0;
    int n_errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Walking-ones expected pattern; errors injected by XOR mask or stuck bit 7
    assign gen_exp  = 8'h01 << gen_addr[2:0];
    assign gen_data = stuck7 ? (gen_exp | 8'h80) : (gen_exp ^ gen_err);

    always @(posedge CLK) begin
        exp_h[1] <= gen_exp;
        dat_h[1] <= gen_data;
        for (int k = 2; k <= 4; k++) begin
            exp_h[k] <= exp_h[k-1];
            dat_h[k] <= dat_h[k-1];
        end
    end

    bist_checker_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_d0 ();
    bist_checker_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_d2 ();
    bist_checker_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_d4 ();
    bist_checker_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_ds ();

    assign if_d0.RD_VALID = gen_valid;
    assign if_d0.RD_ADDR  = gen_addr;
    assign if_d0.RD_DATA  = gen_data;
    assign if_d0.EXPECTED = gen_exp;
    assign if_d2.RD_VALID = gen_valid;
    assign if_d2.RD_ADDR  = gen_addr;
    assign if_d2.RD_DATA  = dat_h[2];
    assign if_d2.EXPECTED = exp_h[2];
    assign if_d4.RD_VALID = gen_valid;
    assign if_d4.RD_ADDR  = gen_addr;
    assign if_d4.RD_DATA  = dat_h[4];
    assign if_d4.EXPECTED = exp_h[4];
    assign if_ds.RD_VALID = gen_valid;
    assign if_ds.RD_ADDR  = gen_addr;
    assign if_ds.RD_DATA  = dat_h[2];
    assign if_ds.EXPECTED = exp_h[2];

    bist_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALIGN_DLY(0), .ERR_CNT_WIDTH(8)) u_d0 (
        .CLK(CLK), .RST(RST), .BIST_EN(BIST_EN), .rd(if_d0),
        .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .FAIL(fail[0]),
        .ERR_CNT(err_cnt[0]), .FIRST_FAIL_ADDR(ffa[0]), .FIRST_FAIL_SYN(ffs[0]),
        .FAIL_BITS(fbits[0])
    );
    bist_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALIGN_DLY(2), .ERR_CNT_WIDTH(8)) u_d2 (
        .CLK(CLK), .RST(RST), .BIST_EN(BIST_EN), .rd(if_d2),
        .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .FAIL(fail[1]),
        .ERR_CNT(err_cnt[1]), .FIRST_FAIL_ADDR(ffa[1]), .FIRST_FAIL_SYN(ffs[1]),
        .FAIL_BITS(fbits[1])
    );
    bist_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALIGN_DLY(4), .ERR_CNT_WIDTH(8)) u_d4 (
        .CLK(CLK), .RST(RST), .BIST_EN(BIST_EN), .rd(if_d4),
        .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .FAIL(fail[2]),
        .ERR_CNT(err_cnt[2]), .FIRST_FAIL_ADDR(ffa[2]), .FIRST_FAIL_SYN(ffs[2]),
        .FAIL_BITS(fbits[2])
    );
    bist_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALIGN_DLY(2), .ERR_CNT_WIDTH(2)) u_sat (
        .CLK(CLK), .RST(RST), .BIST_EN(BIST_EN), .rd(if_ds),
        .BUSY(busy[3]), .DONE(done[3]), .PASS(pass[3]), .FAIL(fail[3]),
        .ERR_CNT(err_sat), .FIRST_FAIL_ADDR(ffa[3]), .FIRST_FAIL_SYN(ffs[3]),
        .FAIL_BITS(fbits[3])
    );

    function automatic logic [7:0] get_err(input int k);
        case (k)
            0:       return err_cnt[0];
            1:       return err_cnt[1];
            2:       return err_cnt[2];
            default: return {6'b0, err_sat};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input int k, input string tag,
                           input logic b, input logic d, input logic p, input logic f,
                           input logic [7:0] e, input logic [3:0] a,
                           input logic [7:0] s, input logic [7:0] fb);
        chk($sformatf("%s[%0d].busy", tag, k), 32'(busy[k]), 32'(b));
        chk($sformatf("%s[%0d].done", tag, k), 32'(done[k]), 32'(d));
        chk($sformatf("%s[%0d].pass", tag, k), 32'(pass[k]), 32'(p));
        chk($sformatf("%s[%0d].fail", tag, k), 32'(fail[k]), 32'(f));
        chk($sformatf("%s[%0d].err_cnt", tag, k), 32'(get_err(k)), 32'(e));
        chk($sformatf("%s[%0d].ff_addr", tag, k), 32'(ffa[k]), 32'(a));
        chk($sformatf("%s[%0d].ff_syn", tag, k), 32'(ffs[k]), 32'(s));
        chk($sformatf("%s[%0d].fail_bits", tag, k), 32'(fbits[k]), 32'(fb));
    endtask

    // Drive one generator cycle at a falling edge; returns at the next
    // falling edge, i.e. after the rising edge that sampled it.
    task automatic step(input logic v, input int addr, input logic [7:0] em);
        gen_valid = v;
        gen_addr  = 4'(addr);
        gen_err   = em;
        @(negedge CLK);
    endtask

    initial begin
        RST       = 1'b0;
        BIST_EN   = 1'b0;
        gen_valid = 1'b0;
        gen_addr  = 4'd0;
        gen_err   = 8'h00;
        stuck7    = 1'b0;
        @(negedge CLK);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int k = 0; k < 4; k++) chk_res(k, "reset", 0, 0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        step(0, 0, 0);

        // ---- Clean pass ----
        BIST_EN = 1'b1;
        step(0, 0, 0);
        chk("clean.busy_start", 32'(busy[1]), 1);
        for (int i = 0; i < 16; i++) step(1, i, 8'h00);
        chk("clean.done_early", 32'(done[1]), 0);
        step(0, 0, 0);
        chk("clean.busy_pre_last", 32'(busy[1]), 1);
        chk("clean.done_pre_last", 32'(done[1]), 0);
        step(0, 0, 0);
        chk_res(1, "clean_last_edge", 0, 1, 1, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0);
        chk_res(0, "clean", 0, 1, 1, 0, 0, 0, 0, 0);
        chk_res(2, "clean", 0, 1, 1, 0, 0, 0, 0, 0);
        chk_res(3, "clean", 0, 1, 1, 0, 0, 0, 0, 0);
        BIST_EN = 1'b0;
        step(0, 0, 0);
        chk_res(1, "idle_hold", 0, 1, 1, 0, 0, 0, 0, 0);

        // ---- Single error at addr 5: 0x24 read, 0x20 expected ----
        BIST_EN = 1'b1;
        step(0, 0, 0);
        chk_res(1, "start_clear", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(1, i, (i == 5) ? 8'h04 : 8'h00);
            if (i == 6) chk("single.fail_before", 32'(fail[1]), 0);
            if (i == 7) begin
                chk("single.fail_at", 32'(fail[1]), 1);
                chk("single.err_at", 32'(err_cnt[1]), 1);
                chk("single.ffa_at", 32'(ffa[1]), 5);
                chk("single.ffs_at", 32'(ffs[1]), 8'h04);
            end
        end
        repeat (4) step(0, 0, 0);
        for (int k = 0; k < 4; k++) chk_res(k, "single", 0, 1, 0, 1, 1, 5, 8'h04, 8'h04);
        BIST_EN = 1'b0;
        step(0, 0, 0);

        // ---- Stuck bit 7: syn 0x80 except where 0x80 is expected ----
        BIST_EN = 1'b1;
        step(0, 0, 0);
        stuck7 = 1'b1;
        for (int i = 0; i < 16; i++) step(1, i, 8'h00);
        repeat (4) step(0, 0, 0);
        stuck7 = 1'b0;
        chk_res(3, "saturate", 0, 1, 0, 1, 3, 0, 8'h80, 8'h80);
        chk_res(1, "stuck7", 0, 1, 0, 1, 14, 0, 8'h80, 8'h80);
        BIST_EN = 1'b0;
        step(0, 0, 0);

        // ---- Gaps: RD_VALID every other cycle ----
        BIST_EN = 1'b1;
        step(0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            step(~i[0], i >> 1, 8'h00);
            if (i == 29) chk("gap.d0_done_15", 32'(done[0]), 0);
        end
        chk("gap.d0_done_16", 32'(done[0]), 1);
        chk("gap.d2_done_15", 32'(done[1]), 0);
        chk("gap.d2_busy_15", 32'(busy[1]), 1);
        chk("gap.d4_done_13", 32'(done[2]), 0);
        repeat (5) step(0, 0, 0);
        for (int k = 0; k < 3; k++) chk_res(k, "gap", 0, 1, 1, 0, 0, 0, 0, 0);
        BIST_EN = 1'b0;
        step(0, 0, 0);

        // ---- Abort after 6 compares (error at addr 3); the compare in
        //      the abort cycle (addr 6, also bad) must be discarded ----
        BIST_EN = 1'b1;
        step(0, 0, 0);
        for (int i = 0; i < 7; i++)
            step(1, i, (i == 3) ? 8'h01 : ((i == 6) ? 8'h02 : 8'h00));
        step(0, 0, 0);
        BIST_EN = 1'b0;
        step(0, 0, 0);
        chk_res(1, "abort", 0, 0, 0, 1, 1, 3, 8'h01, 8'h01);
        BIST_EN = 1'b1;
        step(0, 0, 0);
        chk_res(1, "restart", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, i, 8'h00);
        repeat (2) step(0, 0, 0);
        chk_res(1, "restart_pass", 0, 1, 1, 0, 0, 0, 0, 0);
        BIST_EN = 1'b0;
        step(0, 0, 0);

        // ---- Reset mid-run after 9 compares with 2 errors ----
        BIST_EN = 1'b1;
        step(0, 0, 0);
        for (int i = 0; i < 11; i++)
            step(1, i, (i == 1 || i == 4 || i == 9 || i == 10) ? 8'h10 : 8'h00);
        chk("midrst.err_before", 32'(err_cnt[1]), 2);
        chk("midrst.ffa_before", 32'(ffa[1]), 1);
        RST = 1'b0;
        step(1, 11, 8'h10);
        for (int k = 0; k < 4; k++) chk_res(k, "midrst", 0, 0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        step(0, 0, 0);
        chk_res(1, "rerun", 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0);
        chk_res(1, "no_stale", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, i, 8'h00);
        repeat (2) step(0, 0, 0);
        chk_res(1, "post_rst_pass", 0, 1, 1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
